// File: rtl/asteroids_pkg.sv
// Shared constants, entity field layout and FSM encoding for the collision detector.
package asteroids_pkg;

  localparam int ENTITY_SIZE = 34;
  localparam int ACTIVE_BIT  = 33;
  localparam int Y_HI        = 25;
  localparam int Y_LO        = 16;
  localparam int X_HI        = 15;
  localparam int X_LO        = 6;
  localparam int DIR_HI      = 5;
  localparam int DIR_LO      = 0;

  localparam int COORD_W = 10;
  localparam int BOX_W   = 5;

  localparam logic [BOX_W-1:0] SHIP_BOX = 5'd8;
  localparam logic [BOX_W-1:0] AST_BOX  = 5'd16;
  localparam logic [BOX_W-1:0] SHOT_BOX = 5'd2;

  typedef enum logic [2:0] {
    IDLE,
    SHOT_SCAN,
    EMIT,
    SHIP_SCAN,
    DONE
  } state_t;

  // Only the fields the comparator needs are kept in the snapshot.
  typedef struct packed {
    logic               active;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } ent_t;

  function automatic ent_t unpack_entity(input logic [ENTITY_SIZE-1:0] w);
    ent_t e;
    e.active = w[ACTIVE_BIT];
    e.y      = w[Y_HI:Y_LO];
    e.x      = w[X_HI:X_LO];
    return e;
  endfunction

endpackage

// File: rtl/collision_detector_if.sv
// Hit stream from the collision detector towards the shot controller.
interface collision_detector_if #(
  parameter int MAX_ASTEROIDS = 3,
  parameter int MAX_SHOTS     = 3
);
  logic                             hit_valid;
  logic                             hit_ready;
  logic [$clog2(MAX_SHOTS)-1:0]     hit_shot;
  logic [$clog2(MAX_ASTEROIDS)-1:0] hit_asteroid;

  modport master (output hit_valid, output hit_shot, output hit_asteroid, input hit_ready);
  modport slave  (input hit_valid, input hit_shot, input hit_asteroid, output hit_ready);
endinterface

// File: rtl/bbox_overlap.sv
// Square bounding-box overlap test on half-open intervals, widened by one bit so
// boxes near the right/bottom screen edge never wrap around.
module bbox_overlap
  import asteroids_pkg::*;
(
  input  logic [COORD_W-1:0] i_ax,
  input  logic [COORD_W-1:0] i_ay,
  input  logic [BOX_W-1:0]   i_aw,
  input  logic [COORD_W-1:0] i_bx,
  input  logic [COORD_W-1:0] i_by,
  input  logic [BOX_W-1:0]   i_bw,
  output logic               o_overlap
);
  logic [COORD_W:0] w_ax_end, w_ay_end, w_bx_end, w_by_end;

  assign w_ax_end = {1'b0, i_ax} + {{(COORD_W+1-BOX_W){1'b0}}, i_aw};
  assign w_ay_end = {1'b0, i_ay} + {{(COORD_W+1-BOX_W){1'b0}}, i_aw};
  assign w_bx_end = {1'b0, i_bx} + {{(COORD_W+1-BOX_W){1'b0}}, i_bw};
  assign w_by_end = {1'b0, i_by} + {{(COORD_W+1-BOX_W){1'b0}}, i_bw};

  assign o_overlap = ({1'b0, i_ax} < w_bx_end) && ({1'b0, i_bx} < w_ax_end) &&
                     ({1'b0, i_ay} < w_by_end) && ({1'b0, i_by} < w_ay_end);
endmodule

// File: rtl/collision_detector.sv
// Per-tick collision scan: shot/asteroid pairs first (emitting hits), then ship
// against every asteroid, using a single time-multiplexed box comparator.
module collision_detector
  import asteroids_pkg::*;
#(
  parameter int MAX_ASTEROIDS = 3,
  parameter int MAX_SHOTS     = 3
) (
  input  logic                                           clk,
  input  logic                                           reset_n,
  input  logic                                           start,
  input  logic [ENTITY_SIZE-1:0]                         ship,
  input  logic [MAX_ASTEROIDS-1:0][ENTITY_SIZE-1:0]      asteroids,
  input  logic [MAX_SHOTS-1:0][ENTITY_SIZE-1:0]          shots,
  output logic                                           busy,
  output logic                                           done,
  output logic                                           ship_hit,
  output logic [MAX_ASTEROIDS-1:0]                       ast_hit_mask,
  collision_detector_if.master                           hit_if
);
  localparam int AW = $clog2(MAX_ASTEROIDS);
  localparam int SW = $clog2(MAX_SHOTS);
  localparam logic [AW-1:0] A_LAST = AW'(MAX_ASTEROIDS - 1);
  localparam logic [SW-1:0] S_LAST = SW'(MAX_SHOTS - 1);

  state_t                     r_state;
  ent_t                       r_ship;
  ent_t [MAX_ASTEROIDS-1:0]   r_ast;
  ent_t [MAX_SHOTS-1:0]       r_shots;
  ent_t [MAX_ASTEROIDS-1:0]   w_ast_in;
  ent_t [MAX_SHOTS-1:0]       w_shots_in;
  logic [AW-1:0]              r_a, w_a_next, r_hit_ast;
  logic [SW-1:0]              r_s, w_s_next, r_hit_shot;
  logic [MAX_ASTEROIDS-1:0]   r_mask, r_ast_hit_mask;
  logic [MAX_SHOTS-1:0]       r_spent;
  logic                       r_ship_acc, r_ship_hit, r_busy, r_done, r_hit_valid;
  ent_t                       w_ast_cur, w_shot_cur, w_a_ent;
  logic [BOX_W-1:0]           w_a_box;
  logic                       w_in_ship, w_overlap, w_pair_hit, w_ship_term, w_last_pair;
  logic                       w_unused;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_ASTEROIDS; gi++) begin : g_ast_in
      assign w_ast_in[gi] = unpack_entity(asteroids[gi]);
    end
    for (gi = 0; gi < MAX_SHOTS; gi++) begin : g_shot_in
      assign w_shots_in[gi] = unpack_entity(shots[gi]);
    end
  endgenerate

  // Reserved and direction bits are deliberately ignored.
  assign w_unused = ^{ship, asteroids, shots};

  assign w_ast_cur  = r_ast[r_a];
  assign w_shot_cur = r_shots[r_s];
  assign w_in_ship  = (r_state == SHIP_SCAN);
  assign w_a_ent    = w_in_ship ? r_ship : w_shot_cur;
  assign w_a_box    = w_in_ship ? SHIP_BOX : SHOT_BOX;

  bbox_overlap u_overlap (
    .i_ax      (w_a_ent.x),
    .i_ay      (w_a_ent.y),
    .i_aw      (w_a_box),
    .i_bx      (w_ast_cur.x),
    .i_by      (w_ast_cur.y),
    .i_bw      (AST_BOX),
    .o_overlap (w_overlap)
  );

  assign w_pair_hit  = w_shot_cur.active & w_ast_cur.active & ~r_spent[r_s] & ~r_mask[r_a] & w_overlap;
  assign w_ship_term = r_ship.active & w_ast_cur.active & w_overlap;
  assign w_last_pair = (r_s == S_LAST) && (r_a == A_LAST);
  assign w_a_next    = (r_a == A_LAST) ? '0 : AW'(r_a + 1'b1);
  assign w_s_next    = (r_a == A_LAST) ? SW'(r_s + 1'b1) : r_s;

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_state        <= IDLE;
      r_ship         <= '0;
      r_ast          <= '0;
      r_shots        <= '0;
      r_a            <= '0;
      r_s            <= '0;
      r_mask         <= '0;
      r_spent        <= '0;
      r_ship_acc     <= 1'b0;
      r_ship_hit     <= 1'b0;
      r_ast_hit_mask <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_hit_valid    <= 1'b0;
      r_hit_shot     <= '0;
      r_hit_ast      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_ship     <= unpack_entity(ship);
            r_ast      <= w_ast_in;
            r_shots    <= w_shots_in;
            r_a        <= '0;
            r_s        <= '0;
            r_mask     <= '0;
            r_spent    <= '0;
            r_ship_acc <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= SHOT_SCAN;
          end
        end
        SHOT_SCAN: begin
          if (w_pair_hit) begin
            r_mask[r_a]  <= 1'b1;
            r_spent[r_s] <= 1'b1;
            r_hit_shot   <= r_s;
            r_hit_ast    <= r_a;
            r_hit_valid  <= 1'b1;
            r_state      <= EMIT;
          end else if (w_last_pair) begin
            r_a     <= '0;
            r_state <= SHIP_SCAN;
          end else begin
            r_a <= w_a_next;
            r_s <= w_s_next;
          end
        end
        EMIT: begin
          // The pair indices still point at the hit pair, so resume after it.
          if (hit_if.hit_ready) begin
            r_hit_valid <= 1'b0;
            if (w_last_pair) begin
              r_a     <= '0;
              r_state <= SHIP_SCAN;
            end else begin
              r_a     <= w_a_next;
              r_s     <= w_s_next;
              r_state <= SHOT_SCAN;
            end
          end
        end
        SHIP_SCAN: begin
          r_ship_acc <= r_ship_acc | w_ship_term;
          if (r_a == A_LAST) begin
            r_ship_hit     <= r_ship_acc | w_ship_term;
            r_ast_hit_mask <= r_mask;
            r_done         <= 1'b1;
            r_state        <= DONE;
          end else begin
            r_a <= w_a_next;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy                = r_busy;
  assign done                = r_done;
  assign ship_hit            = r_ship_hit;
  assign ast_hit_mask        = r_ast_hit_mask;
  assign hit_if.hit_valid    = r_hit_valid;
  assign hit_if.hit_shot     = r_hit_shot;
  assign hit_if.hit_asteroid = r_hit_ast;
endmodule

// File: tb/tb_collision_detector.sv
// Self-checking bench for collision_detector: directed scenarios plus randomized
// scenes checked against a behavioural model of the scan rules.
module tb_collision_detector;
  import asteroids_pkg::*;

  localparam int NA = 3;
  localparam int NS = 3;

  logic                              clk = 1'b0;
  logic                              reset_n = 1'b1;
  logic                              start = 1'b0;
  logic [ENTITY_SIZE-1:0]            ship;
  logic [NA-1:0][ENTITY_SIZE-1:0]    asteroids;
  logic [NS-1:0][ENTITY_SIZE-1:0]    shots;
  logic                              busy, done, ship_hit;
  logic [NA-1:0]                     ast_hit_mask;

  collision_detector_if #(.MAX_ASTEROIDS(NA), .MAX_SHOTS(NS)) hif ();

  collision_detector #(.MAX_ASTEROIDS(NA), .MAX_SHOTS(NS)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .ship         (ship),
    .asteroids    (asteroids),
    .shots        (shots),
    .busy         (busy),
    .done         (done),
    .ship_hit     (ship_hit),
    .ast_hit_mask (ast_hit_mask),
    .hit_if       (hif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int         obs_hits[$];
  int         obs_done_cyc;
  int         obs_unstable;
  int         obs_busy_bad;
  logic       obs_ship;
  logic       obs_prev_ship;
  logic       obs_busy_after;
  logic [NA-1:0] obs_mask;

  int         exp_hits[$];
  logic       exp_ship;
  logic [NA-1:0] exp_mask;

  function automatic logic [ENTITY_SIZE-1:0] mk(input bit act, input int x, input int y);
    logic [ENTITY_SIZE-1:0] e;
    e = ENTITY_SIZE'({$urandom, $urandom});
    e[ACTIVE_BIT] = act;
    e[X_HI:X_LO]  = 10'(x);
    e[Y_HI:Y_LO]  = 10'(y);
    return e;
  endfunction

  function automatic int fx(input logic [ENTITY_SIZE-1:0] e);
    return int'(e[X_HI:X_LO]);
  endfunction
  function automatic int fy(input logic [ENTITY_SIZE-1:0] e);
    return int'(e[Y_HI:Y_LO]);
  endfunction

  function automatic bit boxes(input int ax, input int ay, input int aw,
                               input int bx, input int by, input int bw);
    return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bw) && (by < ay + aw);
  endfunction

  // Each shot destroys the lowest-indexed live asteroid it overlaps; shots in index order.
  task automatic model();
    exp_hits.delete();
    exp_mask = '0;
    exp_ship = 1'b0;
    for (int s = 0; s < NS; s++) begin
      if (!shots[s][ACTIVE_BIT]) continue;
      for (int a = 0; a < NA; a++) begin
        if (asteroids[a][ACTIVE_BIT] && !exp_mask[a] &&
            boxes(fx(shots[s]), fy(shots[s]), 2, fx(asteroids[a]), fy(asteroids[a]), 16)) begin
          exp_hits.push_back(s * 4 + a);
          exp_mask[a] = 1'b1;
          break;
        end
      end
    end
    for (int a = 0; a < NA; a++)
      if (ship[ACTIVE_BIT] && asteroids[a][ACTIVE_BIT] &&
          boxes(fx(ship), fy(ship), 8, fx(asteroids[a]), fy(asteroids[a]), 16))
        exp_ship = 1'b1;
  endtask

  task automatic clear_scene();
    ship = mk(0, 500, 500);
    for (int i = 0; i < NA; i++) asteroids[i] = mk(0, 300, 300);
    for (int i = 0; i < NS; i++) shots[i] = mk(0, 700, 700);
  endtask

  // Runs one scan; ready is withheld for `stall` cycles of every hit presentation.
  task automatic run_scan(input int stall);
    int hit_cnt;
    int cur_s, cur_a;
    hit_cnt = 0; cur_s = 0; cur_a = 0;
    obs_hits.delete();
    obs_done_cyc = -1; obs_unstable = 0; obs_busy_bad = 0;
    obs_ship = 1'b0; obs_mask = '0; obs_prev_ship = 1'b0; obs_busy_after = 1'b0;
    @(negedge clk);
    hif.hit_ready = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      if (cyc == 1) obs_prev_ship = ship_hit;
      if (busy !== 1'b1) obs_busy_bad++;
      if (hif.hit_valid === 1'b1) begin
        if (hit_cnt == 0) begin
          cur_s = int'(hif.hit_shot);
          cur_a = int'(hif.hit_asteroid);
          obs_hits.push_back(cur_s * 4 + cur_a);
        end else if (int'(hif.hit_shot) != cur_s || int'(hif.hit_asteroid) != cur_a) begin
          obs_unstable++;
        end
        hif.hit_ready = (hit_cnt >= stall);
        hit_cnt++;
      end else begin
        hit_cnt = 0;
        hif.hit_ready = 1'b0;
      end
      if (done === 1'b1) begin
        obs_done_cyc = cyc;
        obs_ship = ship_hit;
        obs_mask = ast_hit_mask;
        break;
      end
    end
    @(negedge clk);
    hif.hit_ready = 1'b0;
    obs_busy_after = busy;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, hif.hit_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000", {busy, done, hif.hit_valid});
    end
    checks++;
    if ({hif.hit_shot, hif.hit_asteroid, ship_hit, ast_hit_mask} !== '0) begin
      errors++; $display("FAIL reset_data: got shot=%0d ast=%0d ship=%b mask=%b expected zeros",
                         hif.hit_shot, hif.hit_asteroid, ship_hit, ast_hit_mask);
    end
    reset_n = 1'b0;
    $display("test_reset: outputs checked in reset");
  endtask

  task automatic test_single_hit();
    clear_scene();
    shots[0] = mk(1, 60, 60);
    asteroids[1] = mk(1, 50, 50);
    run_scan(0);
    checks++;
    if (obs_hits.size() != 1 || obs_hits[0] != 1) begin
      errors++; $display("FAIL single_hit_idx: got %0d hits (first code %0d) expected 1 hit shot0/ast1",
                         obs_hits.size(), (obs_hits.size() > 0) ? obs_hits[0] : -1);
    end
    checks++;
    if (obs_done_cyc != 14) begin
      errors++; $display("FAIL single_hit_latency: got %0d expected 14", obs_done_cyc);
    end
    checks++;
    if (obs_mask !== 3'b010) begin
      errors++; $display("FAIL single_hit_mask: got %b expected 010", obs_mask);
    end
    checks++;
    if (obs_busy_bad != 0 || obs_busy_after !== 1'b0) begin
      errors++; $display("FAIL single_hit_busy: got %0d low cycles, after=%b expected 0,0",
                         obs_busy_bad, obs_busy_after);
    end
    $display("test_single_hit: done at %0d, mask %b", obs_done_cyc, obs_mask);
  endtask

  task automatic test_edge_touch();
    clear_scene();
    shots[0] = mk(1, 66, 50);
    asteroids[0] = mk(1, 50, 50);
    run_scan(0);
    checks++;
    if (obs_hits.size() != 0 || obs_done_cyc != 13 || obs_mask !== 3'b000) begin
      errors++; $display("FAIL edge_touch: got hits=%0d done=%0d mask=%b expected 0,13,000",
                         obs_hits.size(), obs_done_cyc, obs_mask);
    end
    $display("test_edge_touch: done at %0d, hits %0d", obs_done_cyc, obs_hits.size());
  endtask

  task automatic test_shared_asteroid();
    clear_scene();
    shots[0] = mk(1, 100, 100);
    shots[2] = mk(1, 105, 105);
    asteroids[2] = mk(1, 98, 98);
    run_scan(0);
    checks++;
    if (obs_hits.size() != 1 || obs_hits[0] != 2 || obs_mask !== 3'b100 || obs_done_cyc != 14) begin
      errors++; $display("FAIL shared_asteroid: got hits=%0d first=%0d mask=%b done=%0d expected 1,2,100,14",
                         obs_hits.size(), (obs_hits.size() > 0) ? obs_hits[0] : -1, obs_mask, obs_done_cyc);
    end
    $display("test_shared_asteroid: hits %0d mask %b", obs_hits.size(), obs_mask);
  endtask

  task automatic test_stall();
    clear_scene();
    shots[0] = mk(1, 60, 60);
    asteroids[1] = mk(1, 50, 50);
    run_scan(5);
    checks++;
    if (obs_done_cyc != 19) begin
      errors++; $display("FAIL stall_latency: got %0d expected 19", obs_done_cyc);
    end
    checks++;
    if (obs_unstable != 0 || obs_hits.size() != 1) begin
      errors++; $display("FAIL stall_stability: got unstable=%0d hits=%0d expected 0,1",
                         obs_unstable, obs_hits.size());
    end
    $display("test_stall: done at %0d", obs_done_cyc);
  endtask

  task automatic test_ship();
    clear_scene();
    ship = mk(1, 0, 0);
    asteroids[0] = mk(1, 4, 4);
    run_scan(0);
    checks++;
    if (obs_ship !== 1'b1 || obs_done_cyc != 13) begin
      errors++; $display("FAIL ship_hit_on: got ship=%b done=%0d expected 1,13", obs_ship, obs_done_cyc);
    end
    asteroids[0][ACTIVE_BIT] = 1'b0;
    run_scan(0);
    checks++;
    if (obs_prev_ship !== 1'b1) begin
      errors++; $display("FAIL ship_hit_hold: got %b during next scan expected 1", obs_prev_ship);
    end
    checks++;
    if (obs_ship !== 1'b0) begin
      errors++; $display("FAIL ship_hit_off: got %b expected 0", obs_ship);
    end
    clear_scene();
    ship = mk(1, 2, 100);
    asteroids[0] = mk(1, 1020, 100);
    run_scan(0);
    checks++;
    if (obs_ship !== 1'b0) begin
      errors++; $display("FAIL ship_no_wrap: got %b expected 0", obs_ship);
    end
    $display("test_ship: wrap case ship_hit %b", obs_ship);
  endtask

  task automatic test_random();
    int stall;
    for (int it = 0; it < 25; it++) begin
      ship = mk($urandom_range(0, 3) != 0, $urandom_range(40, 90), $urandom_range(40, 90));
      for (int i = 0; i < NA; i++)
        asteroids[i] = mk($urandom_range(0, 3) != 0, $urandom_range(40, 90), $urandom_range(40, 90));
      for (int i = 0; i < NS; i++)
        shots[i] = mk($urandom_range(0, 3) != 0, $urandom_range(40, 105), $urandom_range(40, 105));
      stall = $urandom_range(0, 3);
      model();
      run_scan(stall);
      checks++;
      if (obs_hits != exp_hits) begin
        errors++; $display("FAIL rand_hits[%0d]: got %0d hits expected %0d (codes s*4+a: got %p want %p)",
                           it, obs_hits.size(), exp_hits.size(), obs_hits, exp_hits);
      end
      checks++;
      if (obs_done_cyc != 13 + exp_hits.size() * (stall + 1)) begin
        errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d",
                           it, obs_done_cyc, 13 + exp_hits.size() * (stall + 1));
      end
      checks++;
      if (obs_mask !== exp_mask || obs_ship !== exp_ship) begin
        errors++; $display("FAIL rand_result[%0d]: got mask=%b ship=%b expected mask=%b ship=%b",
                           it, obs_mask, obs_ship, exp_mask, exp_ship);
      end
      checks++;
      if (obs_unstable != 0 || obs_busy_bad != 0 || obs_busy_after !== 1'b0) begin
        errors++; $display("FAIL rand_handshake[%0d]: got unstable=%0d busy_low=%0d busy_after=%b expected 0,0,0",
                           it, obs_unstable, obs_busy_bad, obs_busy_after);
      end
      $display("test_random[%0d]: stall=%0d hits=%0d done=%0d mask=%b ship=%b",
               it, stall, obs_hits.size(), obs_done_cyc, obs_mask, obs_ship);
    end
  endtask

  task automatic test_reset_mid_emit();
    bit found;
    int done_seen;
    clear_scene();
    ship = mk(1, 52, 52);
    shots[0] = mk(1, 60, 60);
    asteroids[1] = mk(1, 50, 50);
    @(negedge clk);
    hif.hit_ready = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (hif.hit_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL emit_reached: got no hit_valid within 30 cycles expected one");
    end
    #2 reset_n = 1'b1;
    #1;
    checks++;
    if ({busy, done, hif.hit_valid, hif.hit_shot, hif.hit_asteroid, ship_hit, ast_hit_mask} !== '0) begin
      errors++; $display("FAIL reset_abort: got busy=%b done=%b valid=%b shot=%0d ast=%0d ship=%b mask=%b expected zeros",
                         busy, done, hif.hit_valid, hif.hit_shot, hif.hit_asteroid, ship_hit, ast_hit_mask);
    end
    @(negedge clk);
    reset_n = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1 || hif.hit_valid === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++; $display("FAIL reset_no_done: got %0d done/valid cycles expected 0", done_seen);
    end
    clear_scene();
    run_scan(0);
    checks++;
    if (obs_done_cyc != 13 || obs_hits.size() != 0) begin
      errors++; $display("FAIL reset_recover: got done=%0d hits=%0d expected 13,0", obs_done_cyc, obs_hits.size());
    end
    $display("test_reset_mid_emit: recovered scan done at %0d", obs_done_cyc);
  endtask

  initial begin
    hif.hit_ready = 1'b0;
    clear_scene();
    test_reset();
    test_single_hit();
    test_edge_touch();
    test_shared_asteroid();
    test_stall();
    test_ship();
    test_random();
    test_reset_mid_emit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/collision_detector.md
Name: collision_detector

Overview:
- Scans a snapshot of the game entity registers (ship, asteroids, shots) for bounding-box collisions once per game tick. There is one pair comparator, time-multiplexed at one pair per cycle.
- Sits downstream of the entity registers and upstream of shot_controller. Its hit stream drives shot_controller's delete_shot and shot_address inputs, which are currently tied off.
- Also reports ship/asteroid collisions and a per-asteroid hit mask for the game-state logic.

Parameters:
- ENTITY_SIZE, 34: bits per entity word.
- MAX_ASTEROIDS, 3: asteroid slots.
- MAX_SHOTS, 3: shot slots.
- SHIP_BOX, 8: ship bounding-box side, in pixels.
- AST_BOX, 16: asteroid bounding-box side, in pixels.
- SHOT_BOX, 2: shot bounding-box side, in pixels.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset_n  in  1  asynchronous, active-high reset (asserted = 1, despite the name).
- start  in  1  one-cycle scan request; ignored unless in IDLE.
- ship  in  ENTITY_SIZE  ship entity word.
- asteroids  in  [MAX_ASTEROIDS-1:0][ENTITY_SIZE-1:0]  asteroid entity words.
- shots  in  [MAX_SHOTS-1:0][ENTITY_SIZE-1:0]  shot entity words.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse at scan end.
- hit_valid  out  1  a shot/asteroid hit is presented.
- hit_ready  in  1  consumer accepts the hit.
- hit_shot  out  $clog2(MAX_SHOTS)  index of the hitting shot.
- hit_asteroid  out  $clog2(MAX_ASTEROIDS)  index of the asteroid that was hit.
- ship_hit  out  1  ship overlapped an active asteroid in the last completed scan.
- ast_hit_mask  out  MAX_ASTEROIDS  asteroids hit by shots in the last completed scan.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset_n).
- Entity fields:
  - [33] active.
  - [25:16] y.
  - [15:6] x.
  - [5:0] direction/attribute.
  - Remaining bits reserved and ignored.
- Reset value of every output is 0. State resets to IDLE. Snapshot, mask and accumulators reset to 0.
- Reset asserted mid-scan aborts the scan immediately: no done pulse, and any pending hit is dropped.
- FSM states: IDLE, SHOT_SCAN, EMIT, SHIP_SCAN, DONE.
- IDLE:
  - start=1 snapshots ship/asteroids/shots on that edge (cycle 0) and moves to SHOT_SCAN with s=0, a=0.
  - Entity inputs are not looked at again until the next start.
- SHOT_SCAN:
  - Evaluates pair (s,a) each cycle, iterating a fastest.
  - A pair hits iff shot s active, asteroid a active, shot s not yet hit this scan, asteroid a not yet in the working mask, and the boxes overlap.
  - On a hit: set working mask bit a, mark shot s spent, latch hit_shot=s and hit_asteroid=a, go to EMIT.
  - Otherwise advance the pair. After pair (MAX_SHOTS-1, MAX_ASTEROIDS-1), go to SHIP_SCAN with a=0.
- EMIT:
  - hit_valid=1 with hit_shot/hit_asteroid held stable.
  - Leave on the cycle hit_valid & hit_ready is high, then resume SHOT_SCAN at the next pair.
  - The minimum EMIT duration is 1 cycle.
- SHIP_SCAN:
  - One cycle per asteroid.
  - The ship-hit accumulator is ORed with: ship active & asteroid active & overlap.
  - Asteroids already in the working mask are still checked.
- DONE (one cycle):
  - done=1.
  - ship_hit and ast_hit_mask load the accumulators.
  - Return to IDLE. A start in DONE is ignored.
- Latency: with no hits, done asserts in cycle MAX_SHOTS*MAX_ASTEROIDS+MAX_ASTEROIDS+1 (13 with defaults). Each hit adds its EMIT cycles. Inactive entities still consume their pair cycles.
- Overlap uses half-open intervals on both axes: [x, x+w) and [y, y+h). Sums are computed at 11 bits, so there is no screen wrap-around. Touching edges (ax+aw == bx) do not collide.
- Priority: one asteroid is destroyed per shot. Where several shots hit one asteroid, the lowest shot index wins. A shot that hits several asteroids reports only the lowest asteroid index.
- ship_hit and ast_hit_mask hold their values until the next DONE.

Decomposition:
- asteroids_pkg holds:
  - ENTITY_SIZE.
  - Field bit positions (ACTIVE_BIT, Y_HI/Y_LO, X_HI/X_LO, DIR_HI/DIR_LO).
  - Box-size constants.
  - The FSM state enum.
- Sub-module bbox_overlap: combinational. Inputs are two 10-bit (x,y) pairs and two box sizes; output is a 1-bit overlap flag. Instantiated once and muxed between the shot and ship phases.

Test Plan:
- Shot 0 at (60,60) and asteroid 1 at (50,50), start pulse, hit_ready=1 -> one hit_valid cycle with hit_shot=0, hit_asteroid=1; done 14 cycles after start; ast_hit_mask=3'b010.
- Shot 0 at (66,50) and asteroid 0 at (50,50) -> no hit_valid; done in cycle 13; ast_hit_mask=0 (edge-touch case).
- Shots 0 and 2 both overlap asteroid 2 -> exactly one hit, hit_shot=0, hit_asteroid=2.
- hit_ready held low for 5 cycles -> hit_valid and indices stable for 5 cycles; done arrives 5 cycles later than the unstalled run.
- Ship at (0,0), asteroid 0 at (4,4) active, then asteroid 0 inactive -> ship_hit=1 after the first scan and 0 after the second. Also: asteroid at x=1020 with ship at x=2 -> no hit (no wrap).
- reset_n pulsed during EMIT -> all outputs 0 at once, no done pulse; the next start gives a normal 13-cycle scan.
